// File: rtl/udp_dest_port_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : udp_dest_port_filter_pkg
//  Description : Header offsets, protocol constants, FSM and class encodings
//                shared by the UDP destination-port filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package udp_dest_port_filter_pkg;

  localparam int ETH_TYPE_OFS  = 12;
  localparam int IP_VER_OFS    = 14;
  localparam int IP_FRAG_OFS   = 20;
  localparam int IP_PROTO_OFS  = 23;
  localparam int UDP_DPORT_OFS = 36;
  localparam int MIN_HDR_BYTES = 42;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPPROTO_UDP    = 8'h11;
  localparam logic [7:0]  IPV4_VER_IHL5  = 8'h45;
  localparam logic [15:0] IP_FRAG_MASK   = 16'h3FFF;

  typedef enum logic [1:0] {
    HEAD       = 2'd0,
    FWD_MATCH  = 2'd1,
    FWD_BYPASS = 2'd2,
    DROP       = 2'd3
  } filt_state_e;

  typedef enum logic [1:0] {
    CLS_BYPASS = 2'd0,
    CLS_MATCH  = 2'd1,
    CLS_RUNT   = 2'd2
  } pkt_class_e;

  function automatic logic [7:0] hdr_byte(input logic [511:0] data, input int ofs);
    return data[8*ofs +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/udp_dest_port_filter_hdr_classify.sv
`default_nettype none
// ============================================================================
//  Module      : udp_hdr_classify
//  Description : Combinational beat-0 classifier: RUNT, MATCH or BYPASS.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_hdr_classify
  import udp_dest_port_filter_pkg::*;
(
  input  logic [511:0] i_tdata,
  input  logic [63:0]  i_tkeep,
  input  logic [15:0]  i_dest_port,
  output logic [1:0]   o_class
);

  logic        w_runt;
  logic        w_is_match;
  logic [15:0] w_etype;
  logic [15:0] w_frag;
  logic [15:0] w_dport;
  logic [7:0]  w_ver_ihl;
  logic [7:0]  w_proto;
  logic        w_unused_bits;

  assign w_runt    = ~&i_tkeep[MIN_HDR_BYTES-1:0];
  assign w_etype   = {hdr_byte(i_tdata, ETH_TYPE_OFS),  hdr_byte(i_tdata, ETH_TYPE_OFS+1)};
  assign w_frag    = {hdr_byte(i_tdata, IP_FRAG_OFS),   hdr_byte(i_tdata, IP_FRAG_OFS+1)};
  assign w_dport   = {hdr_byte(i_tdata, UDP_DPORT_OFS), hdr_byte(i_tdata, UDP_DPORT_OFS+1)};
  assign w_ver_ihl = hdr_byte(i_tdata, IP_VER_OFS);
  assign w_proto   = hdr_byte(i_tdata, IP_PROTO_OFS);

  // Only IHL=5 headers qualify, so the UDP port always sits at a fixed offset.
  assign w_is_match = (w_etype == ETHERTYPE_IPV4) &&
                      (w_ver_ihl == IPV4_VER_IHL5) &&
                      (w_proto == IPPROTO_UDP) &&
                      ((w_frag & IP_FRAG_MASK) == 16'h0000) &&
                      (w_dport == i_dest_port);

  assign o_class = w_runt     ? CLS_RUNT  :
                   w_is_match ? CLS_MATCH : CLS_BYPASS;

  assign w_unused_bits = ^{i_tdata, i_tkeep};

endmodule
`default_nettype wire

// File: rtl/udp_dest_port_filter.sv
`default_nettype none
// ============================================================================
//  Module      : udp_dest_port_filter
//  Description : Steers each AXIS packet to the partition (UDP dport match)
//                or bypass, drops runts; one output register slice.
//                UDP_FILTER_STATS_EN adds saturating per-class packet counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module udp_dest_port_filter
  import udp_dest_port_filter_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256
)
(
  input  logic                          axis_aclk,
  input  logic                          axis_reset,
  input  logic [15:0]                   DEST_PORT_NUM,

  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,

  output logic [AXIS_DATA_WIDTH-1:0]    m_match_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_match_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_match_axis_tuser,
  output logic                          m_match_axis_tvalid,
  input  logic                          m_match_axis_tready,
  output logic                          m_match_axis_tlast,

  output logic [AXIS_DATA_WIDTH-1:0]    m_bypass_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_bypass_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_bypass_axis_tuser,
  output logic                          m_bypass_axis_tvalid,
  input  logic                          m_bypass_axis_tready,
  output logic                          m_bypass_axis_tlast
`ifdef UDP_FILTER_STATS_EN
  ,
  output logic [31:0]                   stat_match_pkts,
  output logic [31:0]                   stat_bypass_pkts,
  output logic [31:0]                   stat_drop_pkts
`endif
);

  localparam int c_keep_width = AXIS_DATA_WIDTH / 8;

  filt_state_e r_state;
  filt_state_e w_state_nxt;

  logic [1:0]                  w_class;
  logic                        w_route_match;
  logic                        w_route_drop;
  logic                        w_dest_ready;
  logic                        w_slot_free;
  logic                        w_accept;
  logic                        w_load;
  logic                        w_match_sel;
  logic                        w_bypass_sel;

  logic                        r_valid;
  logic                        r_dest;
  logic                        r_last;
  logic [AXIS_DATA_WIDTH-1:0]  r_data;
  logic [c_keep_width-1:0]     r_keep;
  logic [AXIS_TUSER_WIDTH-1:0] r_user;

  udp_hdr_classify u_classify (
    .i_tdata     (s_axis_tdata),
    .i_tkeep     (s_axis_tkeep),
    .i_dest_port (DEST_PORT_NUM),
    .o_class     (w_class)
  );

  // Upstream is only stalled by the master that currently owns the slice,
  // which is what keeps packets in order across both outputs.
  assign w_dest_ready  = r_dest ? m_match_axis_tready : m_bypass_axis_tready;
  assign w_slot_free   = !r_valid || w_dest_ready;
  assign s_axis_tready = !axis_reset && w_slot_free;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_load        = w_accept && !w_route_drop;

  always_comb begin
    w_route_match = 1'b0;
    w_route_drop  = 1'b0;
    w_state_nxt   = r_state;
    case (r_state)
      HEAD: begin
        w_route_match = (w_class == CLS_MATCH);
        w_route_drop  = (w_class == CLS_RUNT);
      end
      FWD_MATCH:  w_route_match = 1'b1;
      FWD_BYPASS: w_route_match = 1'b0;
      DROP:       w_route_drop  = 1'b1;
      default:    w_route_match = 1'b0;
    endcase
    if (w_accept) begin
      if (s_axis_tlast) begin
        w_state_nxt = HEAD;
      end else if (r_state == HEAD) begin
        w_state_nxt = w_route_drop  ? DROP      :
                      w_route_match ? FWD_MATCH : FWD_BYPASS;
      end
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_state <= HEAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_valid <= 1'b0;
      r_dest  <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_user  <= '0;
    end else if (w_slot_free) begin
      r_valid <= w_load;
      if (w_load) begin
        r_dest <= w_route_match;
        r_last <= s_axis_tlast;
        r_data <= s_axis_tdata;
        r_keep <= s_axis_tkeep;
        r_user <= s_axis_tuser;
      end
    end
  end

  assign w_match_sel  = r_valid && r_dest;
  assign w_bypass_sel = r_valid && !r_dest;

  assign m_match_axis_tvalid  = w_match_sel;
  assign m_match_axis_tlast   = w_match_sel  ? r_last : 1'b0;
  assign m_match_axis_tdata   = w_match_sel  ? r_data : '0;
  assign m_match_axis_tkeep   = w_match_sel  ? r_keep : '0;
  assign m_match_axis_tuser   = w_match_sel  ? r_user : '0;

  assign m_bypass_axis_tvalid = w_bypass_sel;
  assign m_bypass_axis_tlast  = w_bypass_sel ? r_last : 1'b0;
  assign m_bypass_axis_tdata  = w_bypass_sel ? r_data : '0;
  assign m_bypass_axis_tkeep  = w_bypass_sel ? r_keep : '0;
  assign m_bypass_axis_tuser  = w_bypass_sel ? r_user : '0;

`ifdef UDP_FILTER_STATS_EN
  logic        w_pkt_done;
  logic [31:0] r_stat_match;
  logic [31:0] r_stat_bypass;
  logic [31:0] r_stat_drop;

  assign w_pkt_done = w_accept && s_axis_tlast;

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      r_stat_match  <= '0;
      r_stat_bypass <= '0;
      r_stat_drop   <= '0;
    end else if (w_pkt_done) begin
      if (w_route_drop) begin
        if (r_stat_drop != 32'hFFFF_FFFF) r_stat_drop <= r_stat_drop + 32'd1;
      end else if (w_route_match) begin
        if (r_stat_match != 32'hFFFF_FFFF) r_stat_match <= r_stat_match + 32'd1;
      end else begin
        if (r_stat_bypass != 32'hFFFF_FFFF) r_stat_bypass <= r_stat_bypass + 32'd1;
      end
    end
  end

  assign stat_match_pkts  = r_stat_match;
  assign stat_bypass_pkts = r_stat_bypass;
  assign stat_drop_pkts   = r_stat_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_udp_dest_port_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udp_dest_port_filter
//  Description : Directed self-checking bench for udp_dest_port_filter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_dest_port_filter;

  localparam logic [63:0] c_keep_all = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] c_keep_40  = 64'h0000_00FF_FFFF_FFFF;

  logic         axis_aclk = 1'b0;
  logic         axis_reset;
  logic [15:0]  DEST_PORT_NUM;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [255:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_match_axis_tdata;
  logic [63:0]  m_match_axis_tkeep;
  logic [255:0] m_match_axis_tuser;
  logic         m_match_axis_tvalid;
  logic         m_match_axis_tready;
  logic         m_match_axis_tlast;
  logic [511:0] m_bypass_axis_tdata;
  logic [63:0]  m_bypass_axis_tkeep;
  logic [255:0] m_bypass_axis_tuser;
  logic         m_bypass_axis_tvalid;
  logic         m_bypass_axis_tready;
  logic         m_bypass_axis_tlast;
`ifdef UDP_FILTER_STATS_EN
  logic [31:0]  stat_match_pkts;
  logic [31:0]  stat_bypass_pkts;
  logic [31:0]  stat_drop_pkts;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 axis_aclk = ~axis_aclk;

  udp_dest_port_filter dut (
    .axis_aclk            (axis_aclk),
    .axis_reset           (axis_reset),
    .DEST_PORT_NUM        (DEST_PORT_NUM),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tkeep         (s_axis_tkeep),
    .s_axis_tuser         (s_axis_tuser),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .m_match_axis_tdata   (m_match_axis_tdata),
    .m_match_axis_tkeep   (m_match_axis_tkeep),
    .m_match_axis_tuser   (m_match_axis_tuser),
    .m_match_axis_tvalid  (m_match_axis_tvalid),
    .m_match_axis_tready  (m_match_axis_tready),
    .m_match_axis_tlast   (m_match_axis_tlast),
    .m_bypass_axis_tdata  (m_bypass_axis_tdata),
    .m_bypass_axis_tkeep  (m_bypass_axis_tkeep),
    .m_bypass_axis_tuser  (m_bypass_axis_tuser),
    .m_bypass_axis_tvalid (m_bypass_axis_tvalid),
    .m_bypass_axis_tready (m_bypass_axis_tready),
    .m_bypass_axis_tlast  (m_bypass_axis_tlast)
`ifdef UDP_FILTER_STATS_EN
    ,
    .stat_match_pkts      (stat_match_pkts),
    .stat_bypass_pkts     (stat_bypass_pkts),
    .stat_drop_pkts       (stat_drop_pkts)
`endif
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] mk_hdr(input logic [15:0] etype, input logic [7:0] vihl,
                                          input logic [15:0] frag, input logic [7:0] proto,
                                          input logic [15:0] dport);
    logic [511:0] b;
    b = {16{32'h1234_5678}};
    b[8*12 +: 8] = etype[15:8];
    b[8*13 +: 8] = etype[7:0];
    b[8*14 +: 8] = vihl;
    b[8*20 +: 8] = frag[15:8];
    b[8*21 +: 8] = frag[7:0];
    b[8*23 +: 8] = proto;
    b[8*36 +: 8] = dport[15:8];
    b[8*37 +: 8] = dport[7:0];
    return b;
  endfunction

  function automatic logic [511:0] body(input logic [15:0] k);
    return {16{16'hC0DE, k}};
  endfunction

  task automatic tick();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic drive(input logic [511:0] d, input logic [63:0] k, input logic l);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = d[511:256];
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic idle();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic mv, input logic bv,
                            input logic [511:0] d, input logic l);
    check({tag, "_match_tvalid"},  m_match_axis_tvalid,  mv);
    check({tag, "_bypass_tvalid"}, m_bypass_axis_tvalid, bv);
    if (mv) begin
      check({tag, "_match_tdata"}, m_match_axis_tdata, d);
      check({tag, "_match_tuser"}, m_match_axis_tuser, d[511:256]);
      check({tag, "_match_tlast"}, m_match_axis_tlast, l);
      check({tag, "_bypass_tdata0"}, m_bypass_axis_tdata, '0);
    end else if (bv) begin
      check({tag, "_bypass_tdata"}, m_bypass_axis_tdata, d);
      check({tag, "_bypass_tlast"}, m_bypass_axis_tlast, l);
      check({tag, "_match_tdata0"}, m_match_axis_tdata, '0);
    end
  endtask

  logic [511:0] hdr_m, hdr_b, hdr_arp, hdr_mf;
  logic [511:0] t5_beat [4];
  logic         rdy_pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  int           in_idx  [6] = '{0, 1, 1, 1, 2, 3};
  int           out_idx [6] = '{0, 0, 0, 1, 2, 3};

  initial begin
    axis_reset           = 1'b1;
    DEST_PORT_NUM        = 16'd4000;
    s_axis_tdata         = '0;
    s_axis_tkeep         = '0;
    s_axis_tuser         = '0;
    s_axis_tvalid        = 1'b0;
    s_axis_tlast         = 1'b0;
    m_match_axis_tready  = 1'b1;
    m_bypass_axis_tready = 1'b1;

    hdr_m   = mk_hdr(16'h0800, 8'h45, 16'h0000, 8'h11, 16'h0FA0);
    hdr_b   = mk_hdr(16'h0800, 8'h45, 16'h0000, 8'h11, 16'h0FA1);
    hdr_arp = mk_hdr(16'h0806, 8'h45, 16'h0000, 8'h11, 16'h0FA0);
    hdr_mf  = mk_hdr(16'h0800, 8'h45, 16'h2000, 8'h11, 16'h0FA0);

    tick();
    tick();
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_match_tvalid", m_match_axis_tvalid, 1'b0);
    check("rst_bypass_tvalid", m_bypass_axis_tvalid, 1'b0);
    check("rst_match_tdata", m_match_axis_tdata, '0);
    check("rst_bypass_tlast", m_bypass_axis_tlast, 1'b0);
    axis_reset = 1'b0;
    tick();

    // matching 3-beat UDP packet
    drive(hdr_m, c_keep_all, 1'b0);
    check("t1_s_tready", s_axis_tready, 1'b1);
    tick(); expect_out("t1_b0", 1'b1, 1'b0, hdr_m, 1'b0);
    drive(body(16'd1), c_keep_all, 1'b0);
    tick(); expect_out("t1_b1", 1'b1, 1'b0, body(16'd1), 1'b0);
    drive(body(16'd2), c_keep_all, 1'b1);
    tick(); expect_out("t1_b2", 1'b1, 1'b0, body(16'd2), 1'b1);
    idle();
    tick(); expect_out("t1_idle", 1'b0, 1'b0, '0, 1'b0);

    // wrong dport then ARP, back to back on bypass
    drive(hdr_b, c_keep_all, 1'b0);
    tick(); expect_out("t2_b0", 1'b0, 1'b1, hdr_b, 1'b0);
    drive(body(16'd3), c_keep_all, 1'b0);
    tick(); expect_out("t2_b1", 1'b0, 1'b1, body(16'd3), 1'b0);
    drive(body(16'd4), c_keep_all, 1'b1);
    tick(); expect_out("t2_b2", 1'b0, 1'b1, body(16'd4), 1'b1);
    drive(hdr_arp, c_keep_all, 1'b0);
    tick(); expect_out("t2_arp0", 1'b0, 1'b1, hdr_arp, 1'b0);
    drive(body(16'd5), c_keep_all, 1'b1);
    tick(); expect_out("t2_arp1", 1'b0, 1'b1, body(16'd5), 1'b1);
    idle();
    tick(); expect_out("t2_idle", 1'b0, 1'b0, '0, 1'b0);
`ifdef UDP_FILTER_STATS_EN
    check("t2_stat_bypass", stat_bypass_pkts, 32'd2);
    check("t2_stat_match", stat_match_pkts, 32'd1);
`endif

    // 40-byte runt is dropped
    drive(hdr_m, c_keep_40, 1'b1);
    check("t3_s_tready", s_axis_tready, 1'b1);
    tick(); expect_out("t3_drop", 1'b0, 1'b0, '0, 1'b0);
    idle();
`ifdef UDP_FILTER_STATS_EN
    check("t3_stat_drop", stat_drop_pkts, 32'd1);
`endif

    // MF fragment goes to bypass despite matching port
    drive(hdr_mf, c_keep_all, 1'b1);
    tick(); expect_out("t4_mf", 1'b0, 1'b1, hdr_mf, 1'b1);
    idle();
    tick(); expect_out("t4_idle", 1'b0, 1'b0, '0, 1'b0);

    // match-path backpressure 1,0,0,1,1,1 on a 4-beat packet
    t5_beat[0] = hdr_m;
    t5_beat[1] = body(16'd11);
    t5_beat[2] = body(16'd12);
    t5_beat[3] = body(16'd13);
    for (int i = 0; i < 6; i++) begin
      m_match_axis_tready = rdy_pat[i];
      drive(t5_beat[in_idx[i]], c_keep_all, in_idx[i] == 3);
      #1;
      check($sformatf("t5_s_tready%0d", i), s_axis_tready, rdy_pat[i]);
      tick();
      expect_out($sformatf("t5_c%0d", i), 1'b1, 1'b0, t5_beat[out_idx[i]], out_idx[i] == 3);
    end
    idle();
    tick(); expect_out("t5_idle", 1'b0, 1'b0, '0, 1'b0);
`ifdef UDP_FILTER_STATS_EN
    check("t5_stat_match", stat_match_pkts, 32'd2);
`endif

    // reset during beat 2; next beat must be parsed as a new header
    drive(hdr_m, c_keep_all, 1'b0);
    tick(); expect_out("t6_b0", 1'b1, 1'b0, hdr_m, 1'b0);
    drive(body(16'd21), c_keep_all, 1'b0);
    tick(); expect_out("t6_b1", 1'b1, 1'b0, body(16'd21), 1'b0);
    drive(body(16'd22), c_keep_all, 1'b0);
    axis_reset = 1'b1;
    #1;
    check("t6_rst_s_tready", s_axis_tready, 1'b0);
    tick(); expect_out("t6_rst", 1'b0, 1'b0, '0, 1'b0);
    axis_reset = 1'b0;
    drive(hdr_arp, c_keep_all, 1'b1);
    tick(); expect_out("t6_new_hdr", 1'b0, 1'b1, hdr_arp, 1'b1);
    idle();
    tick(); expect_out("t6_idle", 1'b0, 1'b0, '0, 1'b0);
`ifdef UDP_FILTER_STATS_EN
    check("t6_stat_bypass", stat_bypass_pkts, 32'd1);
    check("t6_stat_match", stat_match_pkts, 32'd0);
    check("t6_stat_drop", stat_drop_pkts, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/udp_dest_port_filter.md
# udp_dest_port_filter

Ingress steering stage directly upstream of the reconfigurable partition. Parses the Ethernet/IPv4/UDP header in the first 512-bit beat of each AXI4-Stream packet and routes the whole packet either to the partition (UDP, destination port equals DEST_PORT_NUM) or to a bypass path. It drops runt frames. A single registered output slice gives 1-cycle latency at full throughput.

## Interface
- AXIS_DATA_WIDTH, 512, tdata width; fixed at 512 because the header must fit in beat 0.
- AXIS_TUSER_WIDTH, 256, tuser width; passed through unmodified.
- axis_aclk  in  1  sole clock; all logic on the rising edge.
- axis_reset  in  1  synchronous, active-high reset.
- DEST_PORT_NUM  in  16  UDP destination port to match; quasi-static, sampled on beat 0 only.
- s_axis_tdata/tkeep/tuser/tvalid/tready/tlast  in/in/in/in/out/in  512/64/256/1/1/1  input stream.
- m_match_axis_tdata/tkeep/tuser/tvalid/tready/tlast  out/out/out/out/in/out  512/64/256/1/1/1  to the partition.
- m_bypass_axis_tdata/tkeep/tuser/tvalid/tready/tlast  out/out/out/out/in/out  512/64/256/1/1/1  non-matching traffic.

## Operation
- Byte n is at tdata[8n+7:8n]. Multi-byte header fields are big-endian.
- Classification applies to beat 0 only:
  - RUNT: any of tkeep[41:0] is 0.
  - MATCH: not RUNT, and all of the following hold:
    - bytes 12–13 = 0x0800
    - byte 14 = 0x45
    - byte 23 = 0x11
    - bytes 20–21 & 0x3FFF = 0 (no fragment, no MF)
    - bytes 36–37 = DEST_PORT_NUM
  - BYPASS: everything else.
- FSM states:
  - HEAD: waiting for beat 0.
  - FWD_MATCH, FWD_BYPASS, DROP: body of the current packet.
- In HEAD, an accepted beat is classified:
  - tlast=1: routed or dropped per class; stay in HEAD.
  - tlast=0: go to FWD_MATCH, FWD_BYPASS or DROP.
- Body states use the latched route for every beat. An accepted tlast returns the FSM to HEAD.
- DROP consumes beats with no output. A RUNT with tlast=0 drops the whole packet.
- Output slice: one register (data, keep, user, last, valid, dest bit). Only the selected master's tvalid is asserted. The other master's tvalid stays 0, and its data is don't-care, driven 0.
- The filter never reorders packets and never interleaves them across outputs. The bypass path blocks behind a stalled match path and vice versa.

## Timing
- Reset values: FSM=HEAD, both m_*_tvalid=0, m_*_tlast=0, m_*_tdata/tkeep/tuser=0, s_axis_tready=0 while axis_reset=1.
- s_axis_tready = !axis_reset && (!r_valid || ready of r_dest master). In DROP and in HEAD-with-RUNT, s_axis_tready is also asserted when (!r_valid || r_dest master ready). Dropped beats never occupy the slice.
- Latency: an input beat accepted at edge N appears on its master from edge N onward and is valid in cycle N+1.
- Throughput: 1 beat/clk while the selected master is held ready. Back-to-back packets to different outputs have no bubble.
- Once asserted, m_*_tvalid and the payload are held stable until tready.
- Reset mid-packet: the slice is cleared and the FSM goes to HEAD. The next beat is treated as beat 0; upstream is responsible for realignment.
- A DEST_PORT_NUM change takes effect at the next beat 0.

## Configuration
- UDP_FILTER_STATS_EN defined:
  - Adds output ports stat_match_pkts, stat_bypass_pkts, stat_drop_pkts, each 32 bits.
  - Each counter increments by 1 when the tlast of its class is accepted at s_axis.
  - Counters saturate at 0xFFFFFFFF, reset to 0, and are readable on any cycle.
- UDP_FILTER_STATS_EN undefined: the ports and counters are absent; datapath behaviour is identical.

## Structure
- Shared package holds:
  - Header byte-offset constants: ETH_TYPE_OFS=12, IP_VER_OFS=14, IP_FRAG_OFS=20, IP_PROTO_OFS=23, UDP_DPORT_OFS=36, MIN_HDR_BYTES=42.
  - ETHERTYPE_IPV4=16'h0800 and IPPROTO_UDP=8'h11.
  - The FSM state enum {HEAD, FWD_MATCH, FWD_BYPASS, DROP}.
- One sub-module: udp_hdr_classify. It is purely combinational: beat-0 tdata, tkeep and DEST_PORT_NUM in; 2-bit class out.
- The FSM, output slice and counters stay in the top.

## Test plan
- 3-beat IPv4/UDP packet, dport 0x0FA0, DEST_PORT_NUM=4000, both ready=1 -> 3 beats on m_match, payload identical, 1-cycle latency, m_bypass_tvalid never 1.
- Same packet with dport 0x0FA1, then an ARP frame (0x0806) -> both packets emerge on m_bypass with no gap; stat_bypass_pkts=2.
- 1-beat frame with tkeep=64'h0000_00FF_FFFF_FFFF (40 bytes) -> nothing output; s_axis_tready=1; stat_drop_pkts=1.
- IPv4/UDP with MF bit set (bytes 20–21 = 0x2000), dport match -> bypass.
- m_match_tready toggled 1,0,0,1 during a 4-beat match packet -> no beat lost or duplicated; tvalid/tdata stable while stalled; s_axis_tready=0 during stall.
- axis_reset pulsed 1 cycle in the middle of packet beat 2 -> both tvalid=0 next cycle; the following beat is classified as a new header.
